// File: rtl/calc_seq_alu.sv
// Handshaked calculator: single-cycle ADD/SUB/AND/OR/XOR, iterative shift-add MUL
// and restoring DIV, with zero/carry/error flags and valid/ready flow control.
//
// state   | meaning
// IDLE    | in_ready high, waiting for a request
// CALC    | MUL or DIV iterating, one bit per cycle, WIDTH cycles
// DONE    | out_valid high, result and flags held until out_ready
module calc_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_err,
    output logic                 busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [RW-1:0]     result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [WIDTH:0]    sum_ext;
    logic [WIDTH-1:0]  diff;
    logic [RW-1:0]     single_res;
    logic              single_carry;
    logic              single_err;
    logic              multi_start;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_sub;
    logic [RW-1:0]     step_acc;

    // Result of a single-cycle op, evaluated straight from the request inputs.
    always_comb begin
        sum_ext      = {1'b0, a} + {1'b0, b};
        diff         = a - b;
        single_res   = '0;
        single_carry = 1'b0;
        single_err   = 1'b0;
        multi_start  = 1'b0;
        case (op)
            OP_ADD: begin
                single_res   = {{(WIDTH-1){1'b0}}, sum_ext};
                single_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                single_res   = {{WIDTH{1'b0}}, diff};
                single_carry = (a < b);
            end
            OP_MUL: multi_start = 1'b1;
            OP_AND: single_res = {{WIDTH{1'b0}}, a & b};
            OP_DIV: begin
                if (b == '0) begin
                    single_res = {a, {WIDTH{1'b1}}};
                    single_err = 1'b1;
                end else begin
                    multi_start = 1'b1;
                end
            end
            OP_OR:  single_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: single_res = {{WIDTH{1'b0}}, a ^ b};
            default: single_err = 1'b1;
        endcase
    end

    // One iteration: acc holds the product for MUL, {remainder, quotient} for DIV.
    // The partial remainder is always below 2*divisor, so the borrow is the MSB.
    always_comb begin
        div_shift = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
        div_sub   = div_shift - {1'b0, mplier_q};
        step_acc  = acc_q;
        if (is_div_q) begin
            if (!div_sub[WIDTH]) begin
                step_acc = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (mplier_q[0]) begin
            step_acc = acc_q + mcand_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (multi_start) begin
                        state_d  = ST_CALC;
                        busy_d   = 1'b1;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (op == OP_DIV);
                        acc_d    = (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = single_res;
                        zero_d      = (single_res == '0);
                        carry_d     = single_carry;
                        err_d       = single_err;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (!is_div_q) begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    result_d    = step_acc;
                    zero_d      = (step_acc == '0);
                    carry_d     = 1'b0;
                    err_d       = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Self-checking bench for calc_seq_alu (WIDTH=8): directed cases, backpressure,
// reset abort and randomized operations against an arithmetic reference model.
module tb_calc_seq_alu;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     op = 3'd0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           flag_zero;
    logic           flag_carry;
    logic           flag_err;
    logic           busy;

    int errors = 0;
    int checks = 0;

    calc_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_err(flag_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        c;
        logic        e;
        logic [3:0]  lat;
    } dir_t;

    function automatic void ref_model(input logic [2:0] o, input int unsigned av, input int unsigned bv,
                                      output logic [15:0] r, output logic c, output logic e, output int lat);
        r = '0; c = 1'b0; e = 1'b0; lat = 1;
        case (o)
            3'd0: begin r = 16'(av + bv); c = (av + bv) > 255; end
            3'd1: begin r = 16'((av + 256 - bv) % 256); c = (av < bv); end
            3'd2: begin r = 16'(av * bv); lat = W + 1; end
            3'd3: r = 16'(av & bv);
            3'd4: begin
                if (bv == 0) begin r = 16'(av * 256 + 255); e = 1'b1; end
                else begin r = 16'((av % bv) * 256 + av / bv); lat = W + 1; end
            end
            3'd5: r = 16'(av | bv);
            3'd6: r = 16'(av ^ bv);
            default: e = 1'b1;
        endcase
    endfunction

    // Issues one request and waits (bounded) for out_valid; completes the handshake if out_ready is high.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int busy_cyc, output int bad_ready,
                          output logic [15:0] r, output logic z, output logic c, output logic e);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1; busy_cyc = 0; bad_ready = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cyc++;
            if (in_ready) bad_ready++;
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = flag_zero; c = flag_carry; e = flag_err;
        if (in_ready) bad_ready++;
        if (out_valid && out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++; if ({flag_zero, flag_carry, flag_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {flag_zero, flag_carry, flag_err}); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        dir_t vec[9];
        int lat, bc, br;
        logic [15:0] r;
        logic z, c, e;
        vec = '{
            '{3'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 4'd1},
            '{3'd1, 8'd3,  8'd5,  16'h00FE, 1'b1, 1'b0, 4'd1},
            '{3'd1, 8'd5,  8'd5,  16'h0000, 1'b0, 1'b0, 4'd1},
            '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 4'd9},
            '{3'd4, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 4'd9},
            '{3'd4, 8'd42, 8'd0,  16'h2AFF, 1'b0, 1'b1, 4'd1},
            '{3'd7, 8'h5A, 8'hC3, 16'h0000, 1'b0, 1'b1, 4'd1},
            '{3'd5, 8'hA5, 8'h0F, 16'h00AF, 1'b0, 1'b0, 4'd1},
            '{3'd6, 8'hA5, 8'h0F, 16'h00AA, 1'b0, 1'b0, 4'd1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, lat, bc, br, r, z, c, e);
            checks++; if (r !== vec[i].r) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, r, vec[i].r); end
            checks++; if (z !== (vec[i].r == 16'h0)) begin errors++; $display("FAIL dir%0d_zero: got %b want %b", i, z, vec[i].r == 16'h0); end
            checks++; if (c !== vec[i].c) begin errors++; $display("FAIL dir%0d_carry: got %b want %b", i, c, vec[i].c); end
            checks++; if (e !== vec[i].e) begin errors++; $display("FAIL dir%0d_err: got %b want %b", i, e, vec[i].e); end
            checks++; if (lat !== int'(vec[i].lat)) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, vec[i].lat); end
            checks++; if (bc !== int'(vec[i].lat) - 1) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, vec[i].lat - 1); end
            checks++; if (br !== 0) begin errors++; $display("FAIL dir%0d_in_ready_low: got %0d high cycles want 0", i, br); end
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL dir%0d_after_handshake: got valid/ready %b want 01", i, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_backpressure();
        int lat, bc, br;
        logic [15:0] r;
        logic z, c, e;
        out_ready = 1'b0;
        run_op(3'd3, 8'hF0, 8'h3C, lat, bc, br, r, z, c, e);
        checks++; if (r !== 16'h0030) begin errors++; $display("FAIL bp_result: got %h want 0030", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, result} !== {2'b10, 16'h0030}) begin errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b result=%h want 1 0 0030", i, out_valid, in_ready, result); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid/ready %b want 01", {out_valid, in_ready}); end
        checks++; if (result !== 16'h0030) begin errors++; $display("FAIL bp_result_kept: got %h want 0030", result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_ghost: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int rises;
        out_ready = 1'b1;
        @(negedge clk);
        op = 3'd2; a = 8'd255; b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({out_valid, busy, result} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL mid_reset_state: got valid=%b busy=%b result=%h want 0 0 0000", out_valid, busy, result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL mid_no_output: got %0d valid cycles want 0", rises); end
    endtask

    task automatic test_random();
        int lat, bc, br, elat;
        logic [15:0] r, er;
        logic z, c, e, ec, ee;
        logic [2:0] o;
        logic [W-1:0] av, bv;
        out_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = W'($urandom);
            bv = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            ref_model(o, av, bv, er, ec, ee, elat);
            run_op(o, av, bv, lat, bc, br, r, z, c, e);
            checks++;
            if ({r, z, c, e} !== {er, er == 16'h0, ec, ee} || lat !== elat || br !== 0) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got r=%h z=%b c=%b e=%b lat=%0d ready_hi=%0d want r=%h z=%b c=%b e=%b lat=%0d ready_hi=0",
                         i, o, av, bv, r, z, c, e, lat, br, er, er == 16'h0, ec, ee, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
- Parametrised, handshaked successor to the 4-bit single-cycle calculator.
- Operand width is generic (WIDTH); result width is 2*WIDTH.
- Adds an iterative shift-add multiplier, a restoring divider, OR/XOR, status flags and valid/ready flow control.
- Sits between the pin-level input register/decoder and the output mux of the tapeout top level.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..16); result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- op  input  3  opcode.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  operation result.
- flag_zero  output  1  result == 0 over the full 2*WIDTH bits.
- flag_carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- flag_err  output  1  divide-by-zero or reserved opcode.
- busy  output  1  high in CALC state.

Behaviour:
- Reset (rst_n sampled low at a clk edge): state=IDLE, result=0, all flags=0, out_valid=0, busy=0, in_ready=1 the cycle after. Reset mid-CALC or mid-DONE aborts the operation with no output.
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 MUL
  - 011 AND
  - 100 DIV
  - 101 OR
  - 110 XOR
  - 111 reserved
- Codes 000–011 are identical in meaning to the previous calculator.
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. Accept on in_valid && in_ready; operands and opcode are latched at that edge.
  - Single-cycle ops (ADD, SUB, AND, OR, XOR, reserved, DIV with b==0): IDLE -> DONE. out_valid=1 on the cycle after accept (latency 1).
  - MUL, and DIV with b!=0: IDLE -> CALC. Run exactly WIDTH iteration cycles, then go to DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1. result and flags are held stable until out_valid && out_ready. DONE -> IDLE on that edge.
- in_ready=0 in CALC and DONE; there is no overlap of operations.
- Back-to-back throughput for single-cycle ops is one operation per 2 cycles.
- Width rules (unsigned):
  - ADD: result = zero-extended (a+b), WIDTH+1 significant bits; flag_carry = bit WIDTH.
  - SUB: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; upper bits 0; flag_carry = (a<b).
  - MUL: result = full 2*WIDTH-bit product. Radix-2 shift-add, one partial product per cycle.
  - DIV: result = {remainder, quotient}, each WIDTH bits. Restoring algorithm, one quotient bit per cycle, MSB first.
  - DIV with b==0: quotient = all ones, remainder = a, flag_err=1.
  - AND/OR/XOR: bitwise on WIDTH bits, zero-extended.
  - Reserved (111): result=0, flag_err=1; flag_zero=1 follows from result==0.
- flag_zero is computed on the final result for every op.
- Input changes on a, b, op while not accepted have no effect.
- out_ready high in IDLE or CALC is ignored.
- result and flags keep their last value after the DONE->IDLE handshake, until the next result is written.

Test Plan:
- WIDTH=8, ADD a=8'hFF b=8'h01, out_ready=1 -> out_valid on cycle after accept; result=16'h0100; carry=1; zero=0.
- SUB a=3 b=5 -> result=16'h00FE, carry=1. Then SUB a=5 b=5 -> result=16'h0000, zero=1, carry=0.
- MUL a=255 b=255 -> busy for 8 cycles; out_valid exactly 9 cycles after accept; result=16'hFE01; in_ready=0 throughout.
- DIV a=200 b=7 -> result=16'h041C (rem 4, quot 28), latency 9. DIV a=42 b=0 -> result=16'h2AFF, err=1, latency 1.
- Backpressure: AND a=8'hF0 b=8'h3C with out_ready=0 for 5 cycles -> result=16'h0030 held stable, in_ready=0; new in_valid ignored. Completes on the out_ready edge.
- Reset mid-MUL: assert rst_n=0 for 1 cycle at iteration 4 -> out_valid never rises, result=0, in_ready=1 the cycle after release. Also op=111 -> result=0, err=1, zero=1.
